// File: rtl/gen_ramp_zoom_ctrl_if.sv
// Connection bundle between the zoom sequencer, the lock register bank and the ramp generator.
// The master side is the sequencer; the slave side is everything that surrounds it.
interface gen_ramp_zoom_ctrl_if #(
  parameter int R  = 14,
  parameter int CW = 16
);
  logic                 start;
  logic                 abort;
  logic signed [R-1:0]  center;
  logic [R-2:0]         span0;
  logic [CW-1:0]        periods_per_level;
  logic [3:0]           num_levels;
  logic [31:0]          step_base;
  logic                 trigger_low_in;
  logic signed [R-1:0]  ramp_low_lim;
  logic signed [R-1:0]  ramp_hig_lim;
  logic [31:0]          ramp_step;
  logic                 ramp_reset;
  logic                 ramp_enable;
  logic [3:0]           level;
  logic [CW-1:0]        period_cnt;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, abort, center, span0, periods_per_level, num_levels, step_base,
           trigger_low_in,
    output ramp_low_lim, ramp_hig_lim, ramp_step, ramp_reset, ramp_enable, level,
           period_cnt, busy, done
  );

  modport slave (
    output start, abort, center, span0, periods_per_level, num_levels, step_base,
           trigger_low_in,
    input  ramp_low_lim, ramp_hig_lim, ramp_step, ramp_reset, ramp_enable, level,
           period_cnt, busy, done
  );
endinterface

// File: rtl/gen_ramp_zoom_ctrl.sv
// Zoom-search sequencer for the triangular ramp generator: scans a window around a centre,
// halving the span and doubling the dwell after a set number of ramp periods per level.
module gen_ramp_zoom_ctrl #(
  parameter int R       = 14,
  parameter int CW      = 16,
  parameter int RST_CYC = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  gen_ramp_zoom_ctrl_if.master         ctrlBus
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic signed [R:0] MaxVal = {2'b00, {(R-1){1'b1}}};
  localparam logic signed [R:0] MinVal = {2'b11, {(R-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, RUN, NEXT, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [R-1:0]  centerLat_q, centerLat_d;
  logic [R-2:0]         spanLat_q, spanLat_d;
  logic [CW-1:0]        periodsLat_q, periodsLat_d;
  logic [3:0]           levelsLat_q, levelsLat_d;
  logic [31:0]          baseLat_q, baseLat_d;
  logic [RCW-1:0]       rstCnt_q, rstCnt_d;
  logic                 trigPrev_q;
  logic signed [R-1:0]  lowLim_q, lowLim_d, higLim_q, higLim_d;
  logic [31:0]          step_q, step_d;
  logic                 rampReset_q, rampReset_d, rampEnable_q, rampEnable_d;
  logic [3:0]           level_q, level_d;
  logic [CW-1:0]        periodCnt_q, periodCnt_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 trigRise;
  logic [CW-1:0]        cntInc;
  logic [4:0]           lvlInc;
  logic                 enterLoad, enterNext;
  logic signed [R-1:0]  selCenter;
  logic [R-2:0]         selSpan;
  logic [3:0]           selLevel;
  logic [31:0]          selBase;
  logic [R-2:0]         shifted, half;
  logic signed [R:0]    lowWide, higWide;
  logic [46:0]          stepWide;
  logic signed [R-1:0]  newLow, newHig;
  logic [31:0]          newStep;

  function automatic logic signed [R-1:0] satR(input logic signed [R:0] v);
    if (v > MaxVal)      return MaxVal[R-1:0];
    else if (v < MinVal) return MinVal[R-1:0];
    else                 return v[R-1:0];
  endfunction

  // State, latched configuration and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      centerLat_q  <= '0;
      spanLat_q    <= '0;
      periodsLat_q <= '0;
      levelsLat_q  <= '0;
      baseLat_q    <= '0;
      rstCnt_q     <= '0;
      trigPrev_q   <= 1'b0;
      lowLim_q     <= '0;
      higLim_q     <= '0;
      step_q       <= '0;
      rampReset_q  <= 1'b0;
      rampEnable_q <= 1'b0;
      level_q      <= '0;
      periodCnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      centerLat_q  <= centerLat_d;
      spanLat_q    <= spanLat_d;
      periodsLat_q <= periodsLat_d;
      levelsLat_q  <= levelsLat_d;
      baseLat_q    <= baseLat_d;
      rstCnt_q     <= rstCnt_d;
      trigPrev_q   <= ctrlBus.trigger_low_in;
      lowLim_q     <= lowLim_d;
      higLim_q     <= higLim_d;
      step_q       <= step_d;
      rampReset_q  <= rampReset_d;
      rampEnable_q <= rampEnable_d;
      level_q      <= level_d;
      periodCnt_q  <= periodCnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign trigRise = ctrlBus.trigger_low_in & ~trigPrev_q;
  assign cntInc   = periodCnt_q + CW'(1);
  assign lvlInc   = {1'b0, level_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (ctrlBus.start) state_d = LOAD;
      LOAD:       if (rstCnt_q == '0) state_d = RUN;
      RUN: begin
        if (trigRise && (cntInc == periodsLat_q))
          state_d = (lvlInc < {1'b0, levelsLat_q}) ? NEXT : DONE;
      end
      NEXT:       state_d = RUN;
      default:    state_d = IDLE;
    endcase
    if (ctrlBus.abort) state_d = IDLE;
  end

  // A new window is computed from raw inputs at sequence start, otherwise from the latched copy
  always_comb begin
    enterLoad = (state_d == LOAD) && (state_q != LOAD);
    enterNext = (state_d == NEXT);
    if (enterLoad) begin
      selCenter = ctrlBus.center;
      selSpan   = ctrlBus.span0;
      selLevel  = 4'd0;
      selBase   = ctrlBus.step_base;
    end else begin
      selCenter = centerLat_q;
      selSpan   = spanLat_q;
      selLevel  = lvlInc[3:0];
      selBase   = baseLat_q;
    end
    shifted  = selSpan >> selLevel;
    half     = (shifted == '0) ? R'(1) : shifted;
    lowWide  = $signed({selCenter[R-1], selCenter}) - $signed({2'b00, half});
    higWide  = $signed({selCenter[R-1], selCenter}) + $signed({2'b00, half});
    newLow   = satR(lowWide);
    newHig   = satR(higWide);
    stepWide = {15'd0, selBase} << selLevel;
    newStep  = (|stepWide[46:32]) ? 32'hFFFF_FFFF : stepWide[31:0];
  end

  always_comb begin
    centerLat_d  = centerLat_q;
    spanLat_d    = spanLat_q;
    periodsLat_d = periodsLat_q;
    levelsLat_d  = levelsLat_q;
    baseLat_d    = baseLat_q;
    rstCnt_d     = rstCnt_q;
    lowLim_d     = lowLim_q;
    higLim_d     = higLim_q;
    step_d       = step_q;
    level_d      = level_q;
    periodCnt_d  = periodCnt_q;
    if (ctrlBus.abort) begin
      level_d     = '0;
      periodCnt_d = '0;
    end else if (enterLoad) begin
      centerLat_d  = ctrlBus.center;
      spanLat_d    = ctrlBus.span0;
      periodsLat_d = (ctrlBus.periods_per_level == '0) ? CW'(1) : ctrlBus.periods_per_level;
      levelsLat_d  = (ctrlBus.num_levels == '0) ? 4'd1 : ctrlBus.num_levels;
      baseLat_d    = ctrlBus.step_base;
      rstCnt_d     = RCW'(RST_CYC - 1);
      lowLim_d     = newLow;
      higLim_d     = newHig;
      step_d       = newStep;
      level_d      = '0;
      periodCnt_d  = '0;
    end else if (enterNext) begin
      lowLim_d    = newLow;
      higLim_d    = newHig;
      step_d      = newStep;
      level_d     = lvlInc[3:0];
      periodCnt_d = '0;
    end else begin
      if (state_q == LOAD && rstCnt_q != '0) rstCnt_d = rstCnt_q - RCW'(1);
      if (state_q == RUN && trigRise) periodCnt_d = cntInc;
    end
    rampReset_d  = (state_d == LOAD) || ctrlBus.abort;
    rampEnable_d = (state_d == RUN) || (state_d == NEXT) || (state_d == DONE);
    busy_d       = (state_d == LOAD) || (state_d == RUN) || (state_d == NEXT);
    done_d       = (state_d == DONE);
  end

  assign ctrlBus.ramp_low_lim = lowLim_q;
  assign ctrlBus.ramp_hig_lim = higLim_q;
  assign ctrlBus.ramp_step    = step_q;
  assign ctrlBus.ramp_reset   = rampReset_q;
  assign ctrlBus.ramp_enable  = rampEnable_q;
  assign ctrlBus.level        = level_q;
  assign ctrlBus.period_cnt   = periodCnt_q;
  assign ctrlBus.busy         = busy_q;
  assign ctrlBus.done         = done_q;

endmodule

// File: tb/tb_gen_ramp_zoom_ctrl.sv
// Directed bench for the zoom sequencer: level progression, saturation, zero config,
// trigger edge handling, abort/start priority and mid-run reset.
module tb_gen_ramp_zoom_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  gen_ramp_zoom_ctrl_if #(.R(14), .CW(16)) zif ();

  gen_ramp_zoom_ctrl #(.R(14), .CW(16), .RST_CYC(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrlBus (zif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Presents a configuration with start for one edge; returns in the first LOAD cycle
  task automatic applyStimulus(input logic signed [13:0] c, input logic [12:0] s,
                               input logic [15:0] p, input logic [3:0] l,
                               input logic [31:0] b);
    zif.center            = c;
    zif.span0             = s;
    zif.periods_per_level = p;
    zif.num_levels        = l;
    zif.step_base         = b;
    zif.start             = 1'b1;
    tick();
    zif.start             = 1'b0;
  endtask

  task automatic finishLoad();
    repeat (3) tick();
  endtask

  task automatic holdTrigger(input int n);
    zif.trigger_low_in = 1'b1;
    repeat (n) tick();
    zif.trigger_low_in = 1'b0;
    tick();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_low"},   zif.ramp_low_lim, 0);
    checkOutput({tag, "_hig"},   zif.ramp_hig_lim, 0);
    checkOutput({tag, "_step"},  zif.ramp_step,    0);
    checkOutput({tag, "_rrst"},  zif.ramp_reset,   0);
    checkOutput({tag, "_en"},    zif.ramp_enable,  0);
    checkOutput({tag, "_level"}, zif.level,        0);
    checkOutput({tag, "_cnt"},   zif.period_cnt,   0);
    checkOutput({tag, "_busy"},  zif.busy,         0);
    checkOutput({tag, "_done"},  zif.done,         0);
  endtask

  initial begin
    zif.start = 1'b0;
    zif.abort = 1'b0;
    zif.center = '0;
    zif.span0 = '0;
    zif.periods_per_level = '0;
    zif.num_levels = '0;
    zif.step_base = '0;
    zif.trigger_low_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checkResetValues("reset");

    // Level 0 setup and the three-cycle generator reset
    applyStimulus(14'sd100, 13'd400, 16'd2, 4'd3, 32'd10);
    checkOutput("load_rrst1", zif.ramp_reset, 1);
    checkOutput("load_en",    zif.ramp_enable, 0);
    checkOutput("load_busy",  zif.busy, 1);
    checkOutput("l0_low",     zif.ramp_low_lim, -300);
    checkOutput("l0_hig",     zif.ramp_hig_lim, 500);
    checkOutput("l0_step",    zif.ramp_step, 10);
    tick();
    checkOutput("load_rrst2", zif.ramp_reset, 1);
    tick();
    checkOutput("load_rrst3", zif.ramp_reset, 1);
    tick();
    checkOutput("run_rrst",   zif.ramp_reset, 0);
    checkOutput("run_en",     zif.ramp_enable, 1);
    checkOutput("run_busy",   zif.busy, 1);
    zif.center = 14'sd0;
    zif.span0  = 13'd7;
    holdTrigger(1);
    checkOutput("l0_cnt1",    zif.period_cnt, 1);
    holdTrigger(1);
    checkOutput("l1_level",   zif.level, 1);
    checkOutput("l1_cnt",     zif.period_cnt, 0);
    checkOutput("l1_low",     zif.ramp_low_lim, -100);
    checkOutput("l1_hig",     zif.ramp_hig_lim, 300);
    checkOutput("l1_step",    zif.ramp_step, 20);
    checkOutput("l1_en",      zif.ramp_enable, 1);
    holdTrigger(1);
    holdTrigger(1);
    checkOutput("l2_level",   zif.level, 2);
    checkOutput("l2_low",     zif.ramp_low_lim, 0);
    checkOutput("l2_hig",     zif.ramp_hig_lim, 200);
    checkOutput("l2_step",    zif.ramp_step, 40);
    holdTrigger(1);
    holdTrigger(1);
    checkOutput("done_done",  zif.done, 1);
    checkOutput("done_busy",  zif.busy, 0);
    checkOutput("done_en",    zif.ramp_enable, 1);
    checkOutput("done_level", zif.level, 2);
    checkOutput("done_cnt",   zif.period_cnt, 2);
    checkOutput("done_low",   zif.ramp_low_lim, 0);

    // Positive saturation of the high limit and of the step, then abort at level 1
    applyStimulus(14'sd8000, 13'd1000, 16'd1, 4'd4, 32'h8000_0000);
    checkOutput("restart_done", zif.done, 0);
    finishLoad();
    checkOutput("satA_low",   zif.ramp_low_lim, 7000);
    checkOutput("satA_hig",   zif.ramp_hig_lim, 8191);
    checkOutput("satA_step",  zif.ramp_step, 32'h8000_0000);
    holdTrigger(1);
    checkOutput("satA1_level", zif.level, 1);
    checkOutput("satA1_low",   zif.ramp_low_lim, 7500);
    checkOutput("satA1_hig",   zif.ramp_hig_lim, 8191);
    checkOutput("satA1_step",  zif.ramp_step, 32'hFFFF_FFFF);
    zif.abort = 1'b1;
    tick();
    zif.abort = 1'b0;
    checkOutput("abort_rrst",  zif.ramp_reset, 1);
    checkOutput("abort_en",    zif.ramp_enable, 0);
    checkOutput("abort_busy",  zif.busy, 0);
    checkOutput("abort_level", zif.level, 0);
    checkOutput("abort_low",   zif.ramp_low_lim, 7500);
    checkOutput("abort_step",  zif.ramp_step, 32'hFFFF_FFFF);
    tick();
    checkOutput("abort_rrst_off", zif.ramp_reset, 0);
    checkOutput("abort_idle_busy", zif.busy, 0);

    // Negative saturation of the low limit, single level straight to DONE
    applyStimulus(-14'sd8000, 13'd1000, 16'd1, 4'd1, 32'd5);
    finishLoad();
    checkOutput("satB_low",   zif.ramp_low_lim, -8192);
    checkOutput("satB_hig",   zif.ramp_hig_lim, -7000);
    holdTrigger(1);
    checkOutput("satB_done",  zif.done, 1);

    // Minimum half-span of one once the span has shifted away
    applyStimulus(14'sd0, 13'd1, 16'd1, 4'd4, 32'd1);
    finishLoad();
    repeat (3) holdTrigger(1);
    checkOutput("l3_level",   zif.level, 3);
    checkOutput("l3_low",     zif.ramp_low_lim, -1);
    checkOutput("l3_hig",     zif.ramp_hig_lim, 1);
    checkOutput("l3_step",    zif.ramp_step, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetValues("midrst");

    // Start and abort together in IDLE: abort wins
    zif.start = 1'b1;
    zif.abort = 1'b1;
    tick();
    zif.start = 1'b0;
    zif.abort = 1'b0;
    checkOutput("sa_busy",  zif.busy, 0);
    checkOutput("sa_rrst",  zif.ramp_reset, 1);
    tick();
    checkOutput("sa_busy2", zif.busy, 0);
    checkOutput("sa_en",    zif.ramp_enable, 0);
    checkOutput("sa_rrst2", zif.ramp_reset, 0);

    // Zero periods and zero levels behave as one each
    applyStimulus(14'sd50, 13'd10, 16'd0, 4'd0, 32'd3);
    finishLoad();
    checkOutput("zero_low", zif.ramp_low_lim, 40);
    checkOutput("zero_hig", zif.ramp_hig_lim, 60);
    holdTrigger(1);
    checkOutput("zero_done",  zif.done, 1);
    checkOutput("zero_level", zif.level, 0);
    checkOutput("zero_cnt",   zif.period_cnt, 1);

    // A long trigger counts once, and holding it across the level change adds nothing
    applyStimulus(14'sd0, 13'd100, 16'd2, 4'd2, 32'd1);
    finishLoad();
    holdTrigger(5);
    checkOutput("hold_cnt1",  zif.period_cnt, 1);
    holdTrigger(5);
    checkOutput("hold_level", zif.level, 1);
    checkOutput("hold_cnt0",  zif.period_cnt, 0);
    checkOutput("hold_low",   zif.ramp_low_lim, -50);
    checkOutput("hold_hig",   zif.ramp_hig_lim, 50);
    checkOutput("hold_step",  zif.ramp_step, 2);
    checkOutput("hold_busy",  zif.busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gen_ramp_zoom_ctrl.md
Name: gen_ramp_zoom_ctrl

Overview:
- Sequencer that drives the triangular-ramp scan generator through a multi-level "zoom" search.
- Scans a window centred on `center`. After a programmed number of full ramp periods it halves the window span and doubles the step dwell, for up to `num_levels` levels.
- After the last level it keeps scanning the final window and flags done.
- Sits between the lock register bank and the ramp generator, replacing direct register drive of its limits, step, enable and reset.

Parameters:
- R, 14, signal resolution of limits and center (signed).
- CW, 16, width of the periods-per-level counter.
- RST_CYC, 3, number of cycles `ramp_reset` is held at sequence start (covers the generator's 2-stage step pipeline).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  begin sequence (level-sampled in IDLE/DONE).
- abort  in  1  stop sequence, return to IDLE.
- center  in  R  signed scan centre.
- span0  in  R-1  unsigned half-span at level 0.
- periods_per_level  in  CW  ramp periods per level; 0 is treated as 1.
- num_levels  in  4  total levels; 0 is treated as 1.
- step_base  in  32  ramp_step at level 0.
- trigger_low_in  in  1  low-limit trigger from ramp generator.
- ramp_low_lim  out  R  signed low limit to generator.
- ramp_hig_lim  out  R  signed high limit to generator.
- ramp_step  out  32  dwell per ramp value.
- ramp_reset  out  1  generator reset.
- ramp_enable  out  1  generator enable.
- level  out  4  current zoom level.
- period_cnt  out  CW  periods completed in the current level.
- busy  out  1  sequence active (LOAD/RUN/NEXT).
- done  out  1  final level reached.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ramp_low_lim = 0, ramp_hig_lim = 0, ramp_step = 0, ramp_reset = 0, ramp_enable = 0, level = 0, period_cnt = 0, busy = 0, done = 0.
- **States:** IDLE, LOAD, RUN, NEXT, DONE.
- **IDLE:** ramp_enable = 0. On `start` at cycle T:
  - latch center, span0, max(periods_per_level, 1), max(num_levels, 1) and step_base;
  - go to LOAD at T+1.
- **LOAD:**
  - level = 0, period_cnt = 0.
  - Limits are valid from T+1.
  - ramp_reset = 1 for exactly RST_CYC cycles (T+1..T+RST_CYC), ramp_enable = 0.
  - Then go to RUN; ramp_enable = 1 from T+RST_CYC+1.
- **Limit arithmetic:**
  - half = max(span0 >> level, 1).
  - low = center − half, high = center + half, computed in R+1 bits and saturated to the signed R-bit range (−2^(R−1) .. 2^(R−1)−1).
- **Step arithmetic:** ramp_step = step_base << level, saturated to 32'hFFFF_FFFF on overflow.
- **RUN:**
  - Detect the rising edge of trigger_low_in; each edge increments period_cnt.
  - When period_cnt reaches the latched periods value:
    - if level+1 < num_levels, go to NEXT;
    - otherwise go to DONE.
- **NEXT (1 cycle):**
  - level += 1, period_cnt = 0, limits and step recomputed.
  - No ramp_reset; ramp_enable stays 1, and the generator walks into the new window.
  - Triggers arriving in NEXT are ignored.
- **DONE:**
  - done = 1, busy = 0, ramp_enable = 1; final limits are held and triggers are not counted.
  - `start` restarts the sequence via LOAD with the current inputs; done clears when LOAD is entered.
- **Abort:**
  - `abort` in any state → IDLE on the next cycle: ramp_enable = 0, ramp_reset = 1 for one cycle, busy = 0, done = 0, level = 0, period_cnt = 0.
  - Limits and step are held.
- **Priorities:**
  - rst > abort > start > trigger.
  - `start` while in LOAD/RUN/NEXT is ignored.
- **Mid-run input changes:** config inputs are ignored until the next LOAD (latched copy is used).
- **Reset mid-operation:** all state returns to reset values on the next edge, with no residual ramp_reset pulse.

Test Plan:
- **Start, level 0 setup:** rst, then start with center = 100, span0 = 400, periods = 2, levels = 3, step_base = 10 → limits −300/500, step 10, ramp_reset high exactly 3 cycles, then ramp_enable = 1, busy = 1.
- **Level progression:** from the above, 2 trigger pulses → level 1, limits −100/300, step 20; 2 more → level 2, limits 0/200, step 40; 2 more → DONE, done = 1, busy = 0, ramp_enable = 1.
- **Saturation:** center = 8000, span0 = 1000 → hig = 8191, low = 7000; step_base = 32'h8000_0000 at level 1 → step = 32'hFFFF_FFFF; span0 = 1 at level 3 → half = 1.
- **Zero config:** periods = 0, levels = 0 → a single trigger goes straight to DONE.
- **Trigger handling:** trigger_low_in held high 5 cycles → counts one period; trigger pulse during NEXT → not counted.
- **Abort and priority:** abort in RUN at level 1 → IDLE next cycle, one-cycle ramp_reset, level = 0; start and abort in the same cycle in IDLE → remains IDLE; rst mid-RUN → all outputs at reset values.
